// File: rtl/spi_master_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : spi_master_ctrl_pkg
// Purpose  : Shared state encoding and sizing constants for the SPI master
//            controller and its shift register.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
package spi_master_ctrl_pkg;

  // Controller phases: idle, SCLK low half, SCLK high half, CS hold
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Bits moved per transaction and the counter that tracks them
  localparam int c_bits  = 8;
  localparam int c_cnt_w = $clog2(c_bits);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(c_bits - 1);

  // Half-period divider is a fixed 8-bit counter
  localparam int c_div_w = 8;

  // Terminal count of the divider for a given half-period length
  function automatic logic [c_div_w-1:0] div_terminal(input int clk_div);
    return c_div_w'(clk_div - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_ctrl_shreg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : spi_master_ctrl_shreg
// Purpose  : SHIFT_REGISTER_8BIT - 8-bit register with parallel load and
//            MSB-first left shift. Updates only when i_en is high, so the
//            controller strobes it through the data path, never the clock.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module spi_master_ctrl_shreg
  import spi_master_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_sh_ld,
  input  logic              i_s_data_in,
  input  logic [c_bits-1:0] i_p_data_in,
  output logic [c_bits-1:0] o_p_data_out
);

  logic [c_bits-1:0] r_data;
  logic [c_bits-1:0] w_data_nxt;

  // Load has priority over shift; serial data enters at bit 0
  always_comb begin
    w_data_nxt = r_data;
    if (i_en) begin
      if (i_sh_ld) begin
        w_data_nxt = i_p_data_in;
      end else begin
        w_data_nxt = {r_data[c_bits-2:0], i_s_data_in};
      end
    end
  end

  // Storage with asynchronous clear
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_data <= '0;
    end else begin
      r_data <= w_data_nxt;
    end
  end

  assign o_p_data_out = r_data;

endmodule
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : spi_master_ctrl
// Purpose  : Mode-0 (CPOL=0, CPHA=0) MSB-first SPI master moving one byte
//            per START. Drives CS_N/SCLK/MOSI, samples MISO on SCLK rise,
//            returns the received byte with a one-cycle DONE pulse.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_start,
  input  logic [c_bits-1:0] i_tx_data,
  input  logic              i_miso,
  output logic              o_busy,
  output logic              o_done,
  output logic [c_bits-1:0] o_rx_data,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_cs_n
);

  localparam logic [c_div_w-1:0] c_div_max = div_terminal(CLK_DIV);

  // Registered state
  state_t               r_state;
  logic [c_div_w-1:0]   r_div;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_sclk;
  logic                 r_cs_n;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_sample;
  logic [c_bits-1:0]    r_rx_data;

  // Next-state values
  state_t               w_state_nxt;
  logic [c_div_w-1:0]   w_div_nxt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic                 w_sclk_nxt;
  logic                 w_cs_n_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 w_sample_nxt;
  logic                 w_rx_load;

  // Shift register strobes and contents
  logic                 w_sh_en;
  logic                 w_sh_ld;
  logic [c_bits-1:0]    w_shreg;
  logic                 w_div_end;

  assign w_div_end = (r_div == c_div_max);

  spi_master_ctrl_shreg u_shreg (
    .i_clk        (i_clk),
    .i_clr        (i_clr),
    .i_en         (w_sh_en),
    .i_sh_ld      (w_sh_ld),
    .i_s_data_in  (r_sample),
    .i_p_data_in  (i_tx_data),
    .o_p_data_out (w_shreg)
  );

  // Next-state, strobe and output decode for the transaction sequencer
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_cnt_nxt    = r_cnt;
    w_sclk_nxt   = r_sclk;
    w_cs_n_nxt   = r_cs_n;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_sample_nxt = r_sample;
    w_rx_load    = 1'b0;
    w_sh_en      = 1'b0;
    w_sh_ld      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_sh_en     = 1'b1;
          w_sh_ld     = 1'b1;
          w_cs_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_div_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_LOW;
        end
      end

      ST_LOW: begin
        if (w_div_end) begin
          w_sclk_nxt   = 1'b1;
          w_sample_nxt = i_miso;
          w_div_nxt    = '0;
          w_state_nxt  = ST_HIGH;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      ST_HIGH: begin
        if (w_div_end) begin
          w_sclk_nxt  = 1'b0;
          w_sh_en     = 1'b1;
          w_cnt_nxt   = r_cnt + 1'b1;
          w_div_nxt   = '0;
          w_state_nxt = (r_cnt == c_last_bit) ? ST_HOLD : ST_LOW;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      ST_HOLD: begin
        if (w_div_end) begin
          w_cs_n_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_rx_load   = 1'b1;
          w_div_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; CLR aborts any transfer at once
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_cnt     <= '0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sample  <= 1'b0;
      r_rx_data <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sclk   <= w_sclk_nxt;
      r_cs_n   <= w_cs_n_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_sample <= w_sample_nxt;
      if (w_rx_load) begin
        r_rx_data <= w_shreg;
      end
    end
  end

  // MOSI is the register MSB, but held low whenever the slave is deselected
  assign o_mosi    = w_shreg[c_bits-1] & ~r_cs_n;
  assign o_sclk    = r_sclk;
  assign o_cs_n    = r_cs_n;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rx_data = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_spi_master_ctrl
// Purpose  : Self-checking bench for spi_master_ctrl with CLK_DIV=2 and
//            CLK_DIV=1 instances, loopback and mode-0 slave stimulus.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_spi_master_ctrl;

  logic       clk;
  logic       clk_en;
  logic       clr;
  logic [1:0] start;
  logic [1:0] busy;
  logic [1:0] done;
  logic [1:0] sclk;
  logic [1:0] mosi;
  logic [1:0] cs_n;
  logic [1:0] lp;
  logic [1:0] sdrv;
  logic [1:0][7:0] txd;
  logic [1:0][7:0] rxd;
  logic       miso_0;
  logic       miso_1;

  int n_chk;
  int n_pass;

  assign miso_0 = lp[0] ? mosi[0] : sdrv[0];
  assign miso_1 = lp[1] ? mosi[1] : sdrv[1];

  spi_master_ctrl #(.CLK_DIV(2)) u_dut2 (
    .i_clk(clk), .i_clr(clr), .i_start(start[0]), .i_tx_data(txd[0]),
    .i_miso(miso_0), .o_busy(busy[0]), .o_done(done[0]), .o_rx_data(rxd[0]),
    .o_sclk(sclk[0]), .o_mosi(mosi[0]), .o_cs_n(cs_n[0])
  );

  spi_master_ctrl #(.CLK_DIV(1)) u_dut1 (
    .i_clk(clk), .i_clr(clr), .i_start(start[1]), .i_tx_data(txd[1]),
    .i_miso(miso_1), .o_busy(busy[1]), .o_done(done[1]), .o_rx_data(rxd[1]),
    .o_sclk(sclk[1]), .o_mosi(mosi[1]), .o_cs_n(cs_n[1])
  );

  // Clock that can be frozen low for the stopped-clock reset check
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset(input int k, input string tag);
    check_eq({tag, "/sclk"}, 32'(sclk[k]), 0);
    check_eq({tag, "/cs_n"}, 32'(cs_n[k]), 1);
    check_eq({tag, "/mosi"}, 32'(mosi[k]), 0);
    check_eq({tag, "/busy"}, 32'(busy[k]), 0);
    check_eq({tag, "/done"}, 32'(done[k]), 0);
    check_eq({tag, "/rx"},   32'(rxd[k]), 0);
  endtask

  // One transaction, called at a negedge. Expected behaviour: busy for
  // 17*div cycles, 8 SCLK rises, MOSI carries tx MSB first (first bit valid
  // div cycles before the first rise), RX equals what the slave side sent.
  task automatic run_frame(input int k, input int div, input logic [7:0] tx,
                           input logic [7:0] sl, input bit loopb, input bit hold,
                           input bit poke, input string tag);
    int cyc, busy_n, rises, lead, sidx;
    bit prev, seen_rise, fin;
    logic [7:0] seen_mosi, exp_rx;
    cyc = 0; busy_n = 0; rises = 0; lead = 0; sidx = 0;
    prev = 1'b0; seen_rise = 1'b0; fin = 1'b0; seen_mosi = 8'h00;
    exp_rx = loopb ? tx : sl;
    lp[k] = loopb;
    sdrv[k] = sl[7];
    txd[k] = tx;
    start[k] = 1'b1;
    while (!fin && cyc < 40 * div + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check_eq({tag, "/cs_low"}, 32'(cs_n[k]), 0);
        check_eq({tag, "/done_width"}, 32'(done[k]), 0);
        if (!hold) start[k] = 1'b0;
        txd[k] = 8'($urandom);
      end
      if (poke && cyc == 5) begin
        start[k] = 1'b1;
        txd[k] = 8'($urandom);
      end
      if (poke && cyc == 6) start[k] = 1'b0;
      if (busy[k]) busy_n++;
      if (sclk[k] && !prev) begin
        rises++;
        seen_mosi = {seen_mosi[6:0], mosi[k]};
        seen_rise = 1'b1;
      end
      if (!sclk[k] && prev) begin
        sidx++;
        sdrv[k] = (sidx < 8) ? sl[7 - sidx] : 1'b0;
      end
      if (busy[k] && !seen_rise && (mosi[k] == tx[7])) lead++;
      prev = sclk[k];
      if (done[k]) fin = 1'b1;
    end
    check_eq({tag, "/done_seen"}, 32'(fin), 1);
    check_eq({tag, "/busy_cycles"}, 32'(busy_n), 32'(17 * div));
    check_eq({tag, "/sclk_rises"}, 32'(rises), 8);
    check_eq({tag, "/mosi_lead"}, 32'(lead), 32'(div));
    check_eq({tag, "/mosi_at_slave"}, 32'(seen_mosi), 32'(tx));
    check_eq({tag, "/rx"}, 32'(rxd[k]), 32'(exp_rx));
    check_eq({tag, "/end_cs_n"}, 32'(cs_n[k]), 1);
    check_eq({tag, "/end_busy"}, 32'(busy[k]), 0);
    check_eq({tag, "/end_mosi"}, 32'(mosi[k]), 0);
    if (!hold) begin
      @(negedge clk);
      check_eq({tag, "/done_low"}, 32'(done[k]), 0);
      check_eq({tag, "/idle_cs_n"}, 32'(cs_n[k]), 1);
      check_eq({tag, "/idle_sclk"}, 32'(sclk[k]), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, cnt, dn, bz;
    bit prev;
    n_chk = 0; n_pass = 0;
    clk_en = 1'b1; clr = 1'b0; start = '0; txd = '0; lp = '0; sdrv = '0;

    // Reset takes effect before any clock edge
    #1 clr = 1'b1;
    #1;
    check_reset(0, "por0");
    check_reset(1, "por1");
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // Loopback A5
    run_frame(0, 2, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, "loop_a5");

    // CLR while idle clears the held RX byte immediately
    clr = 1'b1;
    #1;
    check_reset(0, "idle_clr");
    #1 clr = 1'b0;
    @(negedge clk);

    // Slave returns 3C while master sends FF; START pulse mid-frame ignored
    run_frame(0, 2, 8'hFF, 8'h3C, 1'b0, 1'b0, 1'b1, "slave_3c");

    // START held high: two frames separated by one CS_N-high cycle
    run_frame(0, 2, 8'h81, 8'h00, 1'b1, 1'b1, 1'b0, "b2b_81");
    run_frame(0, 2, 8'h7E, 8'h00, 1'b1, 1'b1, 1'b0, "b2b_7e");
    start[0] = 1'b0;
    @(negedge clk);
    check_eq("b2b/stop_cs_n", 32'(cs_n[0]), 1);
    check_eq("b2b/stop_busy", 32'(busy[0]), 0);

    // Abort after the 4th SCLK rise, with the clock frozen
    lp[0] = 1'b1; txd[0] = 8'hC3; start[0] = 1'b1;
    r = 0; cnt = 0; prev = 1'b0;
    while (r < 4 && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) start[0] = 1'b0;
      if (sclk[0] && !prev) r++;
      prev = sclk[0];
    end
    check_eq("abort/reached_rise4", 32'(r), 4);
    clk_en = 1'b0;
    #2 clr = 1'b1;
    #1;
    check_reset(0, "abort");
    #1 clr = 1'b0;
    clk_en = 1'b1;
    dn = 0; bz = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[0]) dn++;
      if (busy[0]) bz++;
    end
    check_eq("abort/no_done", 32'(dn), 0);
    check_eq("abort/no_busy", 32'(bz), 0);
    run_frame(0, 2, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, "after_abort_5a");

    // CLK_DIV=1, send 00 while slave drives all ones
    run_frame(1, 1, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, "div1_ff");

    // Randomised frames on both instances
    for (int i = 0; i < 12; i++) begin
      int k;
      k = i % 2;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(k, (k == 0) ? 2 : 1, 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 1'b0, 1'b1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
